// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state and grant encodings for the req/gnt arbiter agents
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_XFER = 2'b10,
        ST_REL  = 2'b11
    } req_state_t;

    // Arbiter grant state: MSB = grant active, low bits = granted port index
    typedef enum logic [2:0] {
        GNT_NONE = 3'b000,
        GNT_0    = 3'b100,
        GNT_1    = 3'b101,
        GNT_2    = 3'b110,
        GNT_3    = 3'b111
    } gnt_state_t;

    localparam int NUM_PORTS = 4;

endpackage

// File: rtl/arb_req_timer.sv
// rtl/arb_req_timer.sv - loadable up-counter that saturates and flags expiry at MAX_WAIT-1
module arb_req_timer #(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    output logic              expired
);

    logic [WAIT_W-1:0] count;

    assign expired = (count == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - client agent: requests the arbiter, issues len+1 beats under grant
module arb_requester
    import arb_pkg::*;
#(
    parameter int LEN_W    = 4,
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             gnt,
    output logic             req,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             beat_last,
    output logic             done,
    output logic             err,
    output logic             busy
);

    req_state_t       state, state_d;
    logic             req_d, done_d, err_d;
    logic [LEN_W-1:0] beat_cnt, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             timer_clr, timer_en, timer_expired;

    arb_req_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .en       (timer_en),
        .load     (1'b0),
        .load_val ({WAIT_W{1'b0}}),
        .expired  (timer_expired)
    );

    // Beats follow gnt combinationally so beat 0 lands in the first granted cycle
    assign beat_valid = ((state == ST_REQ) || (state == ST_XFER)) && gnt;
    assign beat_idx   = beat_cnt;
    assign beat_last  = beat_valid && (beat_cnt == len_q);
    assign cmd_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_d    = state;
        req_d      = req;
        done_d     = 1'b0;
        err_d      = 1'b0;
        beat_cnt_d = beat_cnt;
        len_d      = len_q;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    len_d      = cmd_len;
                    beat_cnt_d = '0;
                    timer_clr  = 1'b1;
                    req_d      = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (gnt) begin
                    if (len_q == '0) begin
                        state_d = ST_REL;
                        done_d  = 1'b1;
                        req_d   = 1'b0;
                    end else begin
                        state_d    = ST_XFER;
                        beat_cnt_d = LEN_W'(1);
                    end
                end else if (timer_expired) begin
                    state_d = ST_REL;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_XFER: begin
                if (!gnt) begin
                    state_d = ST_REL;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                end else if (beat_cnt == len_q) begin
                    state_d = ST_REL;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                end else begin
                    beat_cnt_d = beat_cnt + 1'b1;
                end
            end
            ST_REL: begin
                // Hold off until the arbiter has withdrawn the grant
                req_d = 1'b0;
                if (!gnt) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            req      <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            beat_cnt <= '0;
            len_q    <= '0;
        end else begin
            state    <= state_d;
            req      <= req_d;
            done     <= done_d;
            err      <= err_d;
            beat_cnt <= beat_cnt_d;
            len_q    <= len_d;
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - directed bench for arb_requester on port 2 of a 4-way arbiter
module tb_arb_requester;
    import arb_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_len;
    logic       gnt;
    logic       req;
    logic       beat_valid;
    logic [3:0] beat_idx;
    logic       beat_last;
    logic       done;
    logic       err;
    logic       busy;

    logic       use_arb;
    logic       gnt_force;
    gnt_state_t arb_st;
    logic [3:0] arb_req;
    logic [3:0] arb_gnt;
    logic       both_seen;

    int checks;
    int errors;
    int n;

    arb_requester #(
        .LEN_W    (4),
        .WAIT_W   (8),
        .MAX_WAIT (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .gnt        (gnt),
        .req        (req),
        .beat_valid (beat_valid),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered fixed-priority arbiter; the grantee keeps the grant while it requests
    assign arb_req = {1'b0, req, 2'b00};
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_st <= GNT_NONE;
        end else if (arb_st[2] && arb_req[arb_st[1:0]]) begin
            arb_st <= arb_st;
        end else if (arb_req[0]) begin
            arb_st <= GNT_0;
        end else if (arb_req[1]) begin
            arb_st <= GNT_1;
        end else if (arb_req[2]) begin
            arb_st <= GNT_2;
        end else if (arb_req[3]) begin
            arb_st <= GNT_3;
        end else begin
            arb_st <= GNT_NONE;
        end
    end
    assign arb_gnt = arb_st[2] ? (4'b0001 << arb_st[1:0]) : 4'b0000;
    assign gnt     = use_arb ? arb_gnt[2] : gnt_force;

    always @(negedge clk) begin
        if (done && err) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic [3:0] len);
        cmd_valid = 1'b1;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input int max, output int cnt);
        cnt = 0;
        while (!cmd_ready && cnt < max) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        both_seen = 1'b0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = 4'd0;
        use_arb   = 1'b1;
        gnt_force = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_req",    32'(req),        0);
        check("rst_done",   32'(done),       0);
        check("rst_err",    32'(err),        0);
        check("rst_ready",  32'(cmd_ready),  1);
        check("rst_busy",   32'(busy),       0);
        check("rst_beat",   32'(beat_valid), 0);
        rst = 1'b1;
        @(negedge clk);

        // Uncontended len=3 through the arbiter
        accept(4'd3);
        check("t1_req",   32'(req),        1);
        check("t1_busy",  32'(busy),       1);
        check("t1_nobeat", 32'(beat_valid), 0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("t1_bv",   32'(beat_valid), 1);
            check("t1_idx",  32'(beat_idx),   32'(i));
            check("t1_last", 32'(beat_last),  (i == 3) ? 1 : 0);
            check("t1_done_early", 32'(done), 0);
            step();
        end
        check("t1_done",    32'(done),       1);
        check("t1_req_off", 32'(req),        0);
        check("t1_bv_off",  32'(beat_valid), 0);
        check("t1_ready0",  32'(cmd_ready),  0);
        wait_ready(8, n);
        check("t1_ready_lat", 32'(n), 2);

        // len=0: single beat straight to release
        accept(4'd0);
        step();
        check("t2_bv",   32'(beat_valid), 1);
        check("t2_idx",  32'(beat_idx),   0);
        check("t2_last", 32'(beat_last),  1);
        step();
        check("t2_done", 32'(done),       1);
        check("t2_req",  32'(req),        0);
        check("t2_bv_off", 32'(beat_valid), 0);
        wait_ready(8, n);
        check("t2_ready_lat", 32'(n), 2);

        // Grant timeout, MAX_WAIT=5
        use_arb   = 1'b0;
        gnt_force = 1'b0;
        accept(4'd2);
        for (int k = 1; k < 5; k++) begin
            step();
            check("t3_noerr", 32'(err),        0);
            check("t3_nobv",  32'(beat_valid), 0);
            check("t3_req",   32'(req),        1);
        end
        step();
        check("t3_err",   32'(err),  1);
        check("t3_req0",  32'(req),  0);
        check("t3_done0", 32'(done), 0);
        wait_ready(8, n);
        check("t3_ready_lat", 32'(n), 1);
        check("t3_err_pulse", 32'(err), 0);

        // Grant lost after beat 2 of len=7
        gnt_force = 1'b1;
        accept(4'd7);
        check("t4_b0", 32'(beat_idx), 0);
        step();
        step();
        check("t4_bv2",  32'(beat_valid), 1);
        check("t4_idx2", 32'(beat_idx),   2);
        gnt_force = 1'b0;
        #1;
        check("t4_nobv", 32'(beat_valid), 0);
        step();
        check("t4_err",   32'(err),        1);
        check("t4_done",  32'(done),       0);
        check("t4_req",   32'(req),        0);
        check("t4_nobv2", 32'(beat_valid), 0);
        wait_ready(8, n);
        check("t4_ready_lat", 32'(n), 1);
        check("t4_done2", 32'(done), 0);

        // Grant held high through release
        gnt_force = 1'b1;
        accept(4'd1);
        check("t5_b0", 32'(beat_valid), 1);
        step();
        check("t5_last", 32'(beat_last), 1);
        step();
        check("t5_done", 32'(done), 1);
        for (int k = 0; k < 4; k++) begin
            check("t5_rel_nobv",  32'(beat_valid), 0);
            check("t5_rel_ready", 32'(cmd_ready),  0);
            check("t5_rel_req",   32'(req),        0);
            if (k < 3) step();
        end
        gnt_force = 1'b0;
        step();
        check("t5_idle", 32'(cmd_ready), 1);

        // Async reset mid-burst at beat 4 of len=9, then a clean len=1 burst
        use_arb = 1'b1;
        accept(4'd9);
        step();
        for (int i = 0; i < 4; i++) begin
            check("t6_idx", 32'(beat_idx), 32'(i));
            step();
        end
        check("t6_idx4", 32'(beat_idx),   4);
        check("t6_bv4",  32'(beat_valid), 1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_req",   32'(req),        0);
        check("t6_rst_done",  32'(done),       0);
        check("t6_rst_err",   32'(err),        0);
        check("t6_rst_bv",    32'(beat_valid), 0);
        check("t6_rst_ready", 32'(cmd_ready),  1);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_post_ready", 32'(cmd_ready), 1);
        check("t6_post_err",   32'(err),       0);
        accept(4'd1);
        step();
        check("t6_b0",    32'(beat_idx),  0);
        check("t6_b0_bv", 32'(beat_valid), 1);
        step();
        check("t6_b1",    32'(beat_idx),  1);
        check("t6_b1_last", 32'(beat_last), 1);
        step();
        check("t6_done", 32'(done), 1);
        check("t6_err",  32'(err),  0);
        wait_ready(8, n);
        check("t6_ready_lat", 32'(n), 2);

        check("done_err_excl", 32'(both_seen), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Client-side agent for the 4-way req/gnt fixed-priority arbiter. Connects to one reqN/gntN pair.
- Accepts a burst command from local logic over a valid/ready handshake.
- Raises req, waits for gnt, then issues len+1 beat strobes while the grant is held.
- Drops req and waits for the arbiter to withdraw gnt before taking the next command.
- Aborts with an error pulse if the grant does not arrive in time, or is lost mid-burst.

Parameters:
- LEN_W, 4: width of cmd_len; a burst is cmd_len+1 beats (1..16 at default).
- WAIT_W, 8: width of the grant-wait counter.
- MAX_WAIT, 200: cycles spent in REQ without gnt before abort; must be at least 1 and at most 2^WAIT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_len  in  LEN_W  beats minus one; captured on accept.
- gnt  in  1  grant from arbiter (gntN).
- req  out  1  request to arbiter (reqN); registered.
- beat_valid  out  1  one beat issued this cycle.
- beat_idx  out  LEN_W  index of the current beat, 0..len.
- beat_last  out  1  current beat is the final beat.
- done  out  1  one-cycle pulse; burst completed normally.
- err  out  1  one-cycle pulse; burst aborted (timeout or gnt loss).
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; req=0; done=0; err=0; beat counter=0; wait counter=0; captured len=0. Consequently cmd_ready=1, busy=0, beat_valid=0.
- States: IDLE, REQ, XFER, REL. req=1 in REQ and XFER only, driven from a register.
- beat_valid = (state is REQ or XFER) && gnt. This term is combinational on gnt; every other output is registered.
- beat_idx = beat counter. beat_last = beat_valid && (beat counter == captured len).
- IDLE:
  - cmd_valid && cmd_ready at an edge captures cmd_len, clears both counters, and moves to REQ.
  - cmd_valid with the block not in IDLE is ignored and left pending.
- REQ:
  - gnt=0: wait counter increments. If the counter reaches MAX_WAIT-1 and gnt is still 0, abort: move to REL, err=1 for one cycle, req=0.
  - gnt=1: beat 0 is issued. If len=0, this is the last beat: move to REL with done=1. Otherwise move to XFER with counter=1.
- XFER:
  - gnt=1: one beat per cycle and the counter increments. On the last beat, move to REL with done=1 and req=0 from the next cycle.
  - gnt=0 (grant lost): no beat that cycle; move to REL with err=1.
- REL:
  - req=0 and beats are suppressed, even if gnt is still high.
  - Stay until gnt=0 is sampled, then move to IDLE.
  - Against the registered arbiter, REL lasts 2 cycles after a normal completion.
- Uncontended latency:
  - Accept at edge E0; req high after E0.
  - Arbiter grants at E1; beat 0 is issued in the cycle after E1.
  - Beats run consecutively for len+1 cycles.
  - cmd_ready returns 2 cycles after done.
- done and err are mutually exclusive and never asserted in the same cycle.
- Reset during XFER: req drops immediately and the partial burst is not reported.
- Counter width: the beat counter never exceeds the captured len, so it does not wrap. The wait counter saturates by construction at MAX_WAIT-1.

Decomposition:
- Shared package arb_pkg holds:
  - The state encodings (IDLE=2'b00, REQ=2'b01, XFER=2'b10, REL=2'b11).
  - The arbiter's GNT state codes, for bench reuse.
- One sub-module, arb_req_timer: a loadable up-counter with clear, enable and an expired flag (count == MAX_WAIT-1). It is used for the grant-wait timeout.

Test Plan:
- Uncontended, len=3, paired with a behavioural 4-way arbiter on port 2:
  - req rises 1 cycle after accept.
  - Beats idx 0,1,2,3 on 4 consecutive cycles, beat_last on idx 3.
  - done pulse with req=0 in the next cycle.
  - cmd_ready high 2 cycles later.
- len=0: single beat with beat_last=1 on the same cycle as beat_valid; done next cycle; no XFER state visited.
- Timeout, MAX_WAIT=5, gnt held 0: err pulses exactly 5 cycles after req rises; req=0; no beat_valid ever; returns to IDLE after gnt observed 0.
- Grant loss: len=7, gnt forced low after beat idx 2 → no further beats, err=1 the next cycle, done never asserted.
- REL guard: gnt held high 3 extra cycles after the last beat → no beat_valid, cmd_ready stays 0 until gnt=0, then IDLE.
- Async reset in XFER at idx 4 of len=9: req, done and err go 0 without waiting for a clock edge. After release, cmd_ready=1 and a new len=1 burst completes normally.
